// File: rtl/act_dispatch.sv
// act_dispatch: transmit end of the superblock-row activation interface.
// A controller command ("send LEN words to row R" or to every row) pulls
// words from an upstream valid/ready stream, holds each one and presents it
// to the targeted rows until every targeted row has accepted it.
// Optional build macro: ACT_DISPATCH_STAT_EN adds the stall_cnt output,
// which counts SEND cycles in which no pending row accepted.
module act_dispatch #(
    parameter int N_ROW   = 5,
    parameter int WID_ACT = 16,
    parameter int WID_LEN = 8,
    parameter int WID_ROW = $clog2(N_ROW)
) (
    input  logic                         clk_l,
    input  logic                         rst,
    input  logic                         cmd_vld,
    output logic                         cmd_rdy,
    input  logic [WID_ROW-1:0]           cmd_row,
    input  logic                         cmd_bcast,
    input  logic [WID_LEN-1:0]           cmd_len,
    input  logic [2*WID_ACT-1:0]         src_data,
    input  logic                         src_vld,
    output logic                         src_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
    output logic [N_ROW-1:0]             act_data_in_vld,
    input  logic [N_ROW-1:0]             act_data_in_req,
    output logic                         busy,
    output logic                         done
`ifdef ACT_DISPATCH_STAT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    localparam int DW = 2 * WID_ACT;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DW-1:0]       r_hold;
    logic [N_ROW-1:0]    r_pend;
    logic [WID_LEN-1:0]  r_rem;
    logic [WID_ROW-1:0]  r_row;
    logic                r_bcast;

    logic [N_ROW-1:0]    w_onehot;
    logic [N_ROW-1:0]    w_pend_new;
    logic [N_ROW-1:0]    w_pend_left;
    logic                w_all_clear;
    logic                w_cmd_noop;
    logic                w_cmd_acc;
    logic                w_src_acc;

    // Row decode of the latched target row, and the replicated data bus:
    // every row sees the same held word, only the valids differ.
    generate
        for (genvar gi = 0; gi < N_ROW; gi++) begin : g_row
            assign w_onehot[gi]               = (r_row == WID_ROW'(gi));
            assign act_data_in[gi*DW +: DW]   = r_hold;
        end
    endgenerate

    assign w_pend_new      = r_bcast ? {N_ROW{1'b1}} : w_onehot;
    assign w_pend_left     = r_pend & ~act_data_in_req;
    assign w_all_clear     = (r_pend != '0) && (w_pend_left == '0);
    assign act_data_in_vld = r_pend;

    // A command with zero length or an out-of-range unicast row does nothing.
    assign w_cmd_noop = (cmd_len == '0) ||
                        (!cmd_bcast && (32'(cmd_row) >= 32'(N_ROW)));

    // State register.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs; ready signals are gated by rst
    // so nothing is transferred while reset is asserted.
    always_comb begin
        w_state_next = r_state;
        cmd_rdy      = 1'b0;
        src_rdy      = 1'b0;
        w_cmd_acc    = 1'b0;
        w_src_acc    = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                cmd_rdy = !rst;
                if (cmd_vld && !rst) begin
                    w_cmd_acc    = 1'b1;
                    w_state_next = w_cmd_noop ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                src_rdy = !rst;
                if (src_vld && !rst) begin
                    w_src_acc    = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_all_clear) begin
                    if (r_rem == WID_LEN'(1)) begin
                        w_state_next = S_DONE;
                    end else begin
                        // Last row accepts now: fetch the next word in the
                        // same cycle so unicast streams run at one word/cycle.
                        src_rdy = !rst;
                        if (src_vld && !rst) begin
                            w_src_acc    = 1'b1;
                            w_state_next = S_SEND;
                        end else begin
                            w_state_next = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command fields latched on accept; remaining count steps once per word
    // fully delivered to all its targeted rows.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            r_row   <= '0;
            r_bcast <= 1'b0;
            r_rem   <= '0;
        end else begin
            if (w_cmd_acc) begin
                r_row   <= cmd_row;
                r_bcast <= cmd_bcast;
                r_rem   <= cmd_len;
            end else if ((r_state == S_SEND) && w_all_clear) begin
                r_rem   <= r_rem - WID_LEN'(1);
            end
        end
    end

    // Hold register and pending-row mask: a new word reloads the mask,
    // otherwise rows drop out of the mask as they accept.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_pend <= '0;
        end else begin
            if (w_src_acc) begin
                r_hold <= src_data;
                r_pend <= w_pend_new;
            end else if (r_state == S_SEND) begin
                r_pend <= w_pend_left;
            end
        end
    end

`ifdef ACT_DISPATCH_STAT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of SEND cycles where no pending row accepted.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_cmd_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_SEND) && (r_pend != '0) &&
                     ((r_pend & act_data_in_req) == '0) &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_act_dispatch.sv
// Testbench for act_dispatch: directed scenarios plus randomized commands,
// checked against a word-delivery model (per-row received-word counts and
// the ordered list of words each command should deliver).
module tb_act_dispatch;

    localparam int N_ROW   = 5;
    localparam int WID_ACT = 16;
    localparam int WID_LEN = 8;
    localparam int WID_ROW = 3;
    localparam int DW      = 2 * WID_ACT;

    logic                       clk_l = 1'b0;
    logic                       rst;
    logic                       cmd_vld;
    logic                       cmd_rdy;
    logic [WID_ROW-1:0]         cmd_row;
    logic                       cmd_bcast;
    logic [WID_LEN-1:0]         cmd_len;
    logic [DW-1:0]              src_data;
    logic                       src_vld;
    logic                       src_rdy;
    logic [DW*N_ROW-1:0]        act_data_in;
    logic [N_ROW-1:0]           act_data_in_vld;
    logic [N_ROW-1:0]           act_data_in_req;
    logic                       busy;
    logic                       done;
`ifdef ACT_DISPATCH_STAT_EN
    logic [31:0]                stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    act_dispatch #(
        .N_ROW   (N_ROW),
        .WID_ACT (WID_ACT),
        .WID_LEN (WID_LEN),
        .WID_ROW (WID_ROW)
    ) dut (
        .clk_l           (clk_l),
        .rst             (rst),
        .cmd_vld         (cmd_vld),
        .cmd_rdy         (cmd_rdy),
        .cmd_row         (cmd_row),
        .cmd_bcast       (cmd_bcast),
        .cmd_len         (cmd_len),
        .src_data        (src_data),
        .src_vld         (src_vld),
        .src_rdy         (src_rdy),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req),
        .busy            (busy),
        .done            (done)
`ifdef ACT_DISPATCH_STAT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk_l = ~clk_l;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command end to end. Inputs change on the falling edge; outputs are
    // sampled 1 time unit later, and the handshakes that the coming rising
    // edge will perform are applied to the model at that point.
    // st_row/st_word/st_len force req low on one row for st_len cycles once
    // that row first shows word number st_word.
    task automatic run_cmd(input int row, input bit bc, input int len,
                           input int req_pct, input int src_pct, input bit seq,
                           input int st_row, input int st_word, input int st_len,
                           output int first_vld, output int done_cyc);
        logic [DW-1:0]    words[$];
        int               cnt[N_ROW];
        logic [N_ROW-1:0] tgt;
        logic [N_ROW-1:0] req;
        bit               noop;
        bit               all_in;
        int               eff_len;
        int               consumed;
        int               fin;
        int               stall_left;
        noop       = (len == 0) || (!bc && row >= N_ROW);
        eff_len    = noop ? 0 : len;
        tgt        = noop ? '0 : (bc ? {N_ROW{1'b1}} : N_ROW'(1 << row));
        consumed   = 0;
        fin        = noop ? 0 : -1;
        stall_left = -1;
        first_vld  = -1;
        done_cyc   = -1;
        for (int i = 0; i < N_ROW; i++) cnt[i] = 0;
        for (int k = 0; k < len; k++)
            words.push_back(seq ? DW'(32'h0001_0001 * (k + 1)) : DW'($urandom));

        @(negedge clk_l);
        cmd_vld         = 1'b1;
        cmd_row         = WID_ROW'(row);
        cmd_bcast       = bc;
        cmd_len         = WID_LEN'(len);
        src_vld         = 1'b0;
        act_data_in_req = '0;
        #1;
        chk("cmd_rdy_idle", cmd_rdy, 1);
        chk("busy_idle", busy, 0);

        for (int cyc = 1; cyc < 1000 && done_cyc < 0; cyc++) begin
            @(negedge clk_l);
            // Keep a (garbage) command offered while busy: it must be ignored.
            cmd_row = WID_ROW'($urandom);
            cmd_len = WID_LEN'($urandom);
            for (int i = 0; i < N_ROW; i++) begin
                req[i] = ($urandom_range(99) < req_pct);
                if (i == st_row && act_data_in_vld[i] && cnt[i] == st_word && stall_left != 0) begin
                    if (stall_left < 0) stall_left = st_len;
                    req[i] = 1'b0;
                    stall_left--;
                end
            end
            act_data_in_req = req;
            src_vld  = ($urandom_range(99) < src_pct);
            src_data = (consumed < len) ? words[consumed] : DW'($urandom);
            #1;
            chk("done", done, (fin >= 0 && cyc == fin + 1));
            chk("busy", busy, 1);
            chk("cmd_rdy_busy", cmd_rdy, 0);
            chk("vld_untargeted", act_data_in_vld & ~tgt, 0);
            if (act_data_in_vld != '0) begin
                if (first_vld < 0) first_vld = cyc;
                for (int i = 0; i < N_ROW; i++) begin
                    if (consumed > 0)
                        chk("slice_word", act_data_in[i*DW +: DW], words[consumed-1]);
                    if (act_data_in_vld[i]) begin
                        chk("vld_extra", cnt[i] < eff_len, 1);
                        if (cnt[i] < eff_len)
                            chk("row_data", act_data_in[i*DW +: DW], words[cnt[i]]);
                    end
                end
            end
            // Row transfers at the coming edge.
            for (int i = 0; i < N_ROW; i++)
                if (act_data_in_vld[i] && act_data_in_req[i]) cnt[i]++;
            // A new word may only be taken once every targeted row has all
            // words consumed so far.
            if (src_vld && src_rdy) begin
                chk("src_overconsume", consumed < eff_len, 1);
                for (int i = 0; i < N_ROW; i++)
                    if (tgt[i]) chk("src_early", cnt[i], consumed);
                consumed++;
            end
            all_in = 1'b1;
            for (int i = 0; i < N_ROW; i++)
                if (tgt[i] && cnt[i] != eff_len) all_in = 1'b0;
            if (fin < 0 && eff_len > 0 && all_in) fin = cyc;
            if (done) done_cyc = cyc;
        end
        chk("done_seen", done_cyc >= 0, 1);

        @(negedge clk_l);
        cmd_vld         = 1'b0;
        src_vld         = 1'b0;
        act_data_in_req = '0;
        #1;
        chk("done_after", done, 0);
        chk("busy_after", busy, 0);
        chk("cmd_rdy_after", cmd_rdy, 1);
        chk("vld_after", act_data_in_vld, 0);
        chk("src_count", consumed, eff_len);
        for (int i = 0; i < N_ROW; i++)
            if (tgt[i]) chk("row_count", cnt[i], eff_len);
    endtask

    initial begin
        int fv;
        int dc;
        rst             = 1'b1;
        cmd_vld         = 1'b1;
        cmd_row         = '0;
        cmd_bcast       = 1'b0;
        cmd_len         = 8'd3;
        src_data        = '0;
        src_vld         = 1'b1;
        act_data_in_req = '1;

        // Reset state, with handshakes offered on both inputs.
        repeat (2) @(negedge clk_l);
        #1;
        chk("rst_vld", act_data_in_vld, 0);
        chk("rst_data", act_data_in, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_src_rdy", src_rdy, 0);
        @(negedge clk_l);
        cmd_vld = 1'b0;
        src_vld = 1'b0;
        rst     = 1'b0;

        // Unicast row 2, four sequential words, no backpressure.
        run_cmd(2, 0, 4, 100, 100, 1, -1, 0, 0, fv, dc);
        chk("t1_first_vld", fv, 2);
        chk("t1_done_cyc", dc, 6);

        // Same, with row 2 stalled 3 cycles on the second word.
        run_cmd(2, 0, 4, 100, 100, 1, 2, 1, 3, fv, dc);
        chk("t2_first_vld", fv, 2);
        chk("t2_done_cyc", dc, 9);

        // Broadcast of two words, row 0 late by 2 cycles on the first.
        run_cmd(0, 1, 2, 100, 100, 1, 0, 0, 2, fv, dc);
        chk("t3_done_cyc", dc, 6);

        // No-op commands: zero length, and unicast to a missing row.
        run_cmd(1, 0, 0, 100, 100, 0, -1, 0, 0, fv, dc);
        chk("t4a_done_cyc", dc, 1);
        chk("t4a_no_vld", fv, -1);
        run_cmd(7, 0, 3, 100, 100, 0, -1, 0, 0, fv, dc);
        chk("t4b_done_cyc", dc, 1);
        chk("t4b_no_vld", fv, -1);

        // Reset in the middle of a four-word command to row 1.
        @(negedge clk_l);
        cmd_vld = 1'b1; cmd_row = 3'd1; cmd_bcast = 1'b0; cmd_len = 8'd4;
        act_data_in_req = '1; src_vld = 1'b1; src_data = 32'hA5A5_0001;
        @(negedge clk_l);
        cmd_vld = 1'b0;
        #1;
        chk("t5_load_src_rdy", src_rdy, 1);
        @(negedge clk_l);
        src_data = 32'hA5A5_0002;
        #1;
        chk("t5_vld_w1", act_data_in_vld, 5'b00010);
        chk("t5_data_w1", act_data_in[1*DW +: DW], 32'hA5A5_0001);
        @(negedge clk_l);
        #1;
        chk("t5_vld_w2", act_data_in_vld, 5'b00010);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_vld", act_data_in_vld, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_src_rdy", src_rdy, 0);
        repeat (2) begin
            @(negedge clk_l);
            #1;
            chk("t5_rst_done_hold", done, 0);
        end
        @(negedge clk_l);
        rst     = 1'b0;
        src_vld = 1'b0;
        run_cmd(0, 0, 1, 100, 100, 0, -1, 0, 0, fv, dc);
        chk("t5_after_done_cyc", dc, 3);

`ifdef ACT_DISPATCH_STAT_EN
        // Stall counter: five stalled SEND cycles, cleared by the next accept.
        run_cmd(3, 0, 1, 100, 100, 0, 3, 0, 5, fv, dc);
        chk("t6_done_cyc", dc, 8);
        chk("t6_stall_cnt", stall_cnt, 5);
        run_cmd(2, 0, 0, 100, 100, 0, -1, 0, 0, fv, dc);
        chk("t6_stall_clr", stall_cnt, 0);
`endif

        // Randomized commands, rows, lengths, backpressure and source gaps.
        for (int n = 0; n < 30; n++) begin
            run_cmd(int'($urandom_range(7)), 1'($urandom_range(1)), int'($urandom_range(6)),
                    int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0,
                    -1, 0, 0, fv, dc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
